route32: RTL and testbench
==========================

ROUTE32 -- requirements
Module: route32

Interface
REQ-001 Parameter: WIDTH, 32, data width of input and both output lanes.
REQ-002 Parameter: CNT_W, 8, width of per-lane accepted-word counters.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 IN  input  WIDTH  data word to be steered.
REQ-006 IN_VALID  input  1  IN holds a valid word.
REQ-007 COND  input  1  destination select: 1 -> lane 1, 0 -> lane 0; sampled with IN.
REQ-008 IN_READY  output  1  block accepts IN this cycle.
REQ-009 OUT0 / OUT1  output  WIDTH each  lane 0 / lane 1 held data.
REQ-010 OUT0_VALID / OUT1_VALID  output  1 each  lane holds a valid word.
REQ-011 OUT0_READY / OUT1_READY  input  1 each  lane consumer takes word this cycle.
REQ-012 CNT0 / CNT1  output  CNT_W each  count of words accepted into lane 0 / lane 1.

Function
REQ-013 Transfer on input side SHALL occur when IN_VALID && IN_READY at a rising CLK edge.
REQ-014 Transfer on lane k SHALL occur when OUTk_VALID && OUTk_READY at a rising CLK edge.
REQ-015 IN_READY SHALL equal (!OUT1_VALID || OUT1_READY) when COND=1, else (!OUT0_VALID || OUT0_READY); combinational, low while RST=1.
REQ-016 An accepted word SHALL appear on OUTk with OUTk_VALID=1 the cycle after acceptance (latency 1), k = COND at acceptance.
REQ-017 Unselected lane SHALL be unaffected by an input transfer (data, valid, counter hold).
REQ-018 While OUTk_VALID=1 and OUTk_READY=0, OUTk SHALL hold stable and OUTk_VALID SHALL stay 1.
REQ-019 Lane k drained with no same-cycle fill SHALL clear OUTk_VALID next cycle; OUTk keeps last value.
REQ-020 Simultaneous drain and fill of lane k SHALL load the new word with OUTk_VALID remaining 1 (full throughput, no bubble).
REQ-021 Both lanes SHALL drain independently in the same cycle.
REQ-022 COND and IN changing while IN_VALID=0 SHALL have no effect on state.
REQ-023 CNTk SHALL increment by 1 per word accepted into lane k, wrapping 2^CNT_W-1 -> 0 with no flag.
REQ-024 Sustained back-pressure (OUTk_READY=0, lane k full) SHALL stall only words targeting lane k; words for the other lane SHALL still be accepted.

Reset
REQ-025 RST=1 at a rising edge SHALL set OUT0=OUT1=0, OUT0_VALID=OUT1_VALID=0, CNT0=CNT1=0.
REQ-026 Reset mid-operation SHALL discard held words; input presented during RST=1 SHALL NOT be accepted or counted.
REQ-027 First acceptance SHALL be possible in the first cycle with RST=0.

Structure
REQ-028 WIDTH and CNT_W defaults SHALL live in a shared package used by the CPU datapath blocks.
REQ-029 Each lane (holding register, valid flag, counter) SHALL be one sub-module, lane_reg32, instantiated twice.
REQ-030 Top level SHALL contain only IN_READY selection and per-lane load-enable decode.

Verification
REQ-031 Reset, then IN=0xDEADBEEF, COND=1, IN_VALID=1 one cycle -> next cycle OUT1=0xDEADBEEF, OUT1_VALID=1, OUT0_VALID=0, CNT1=1, CNT0=0.
REQ-032 Lane 0 full with OUT0_READY=0, present IN=0x11111111 COND=0 -> IN_READY=0, OUT0 unchanged; switch COND=1 -> accepted into lane 1.
REQ-033 OUT0_READY=1 held, 4 back-to-back words 0x1..0x4 COND=0 -> IN_READY=1 every cycle, OUT0 shows 0x1..0x4 on consecutive cycles, CNT0=4.
REQ-034 Accept 256 words into lane 1 -> CNT1 wraps to 0, CNT0 stays 0.
REQ-035 Both lanes full, assert RST for one cycle with IN_VALID=1 -> OUT0_VALID=OUT1_VALID=0, counters 0, IN_READY=0 during reset, no word accepted.
REQ-036 Lane 1 full, OUT1_READY=1 and IN=0xA5A5A5A5 COND=1 same cycle -> next cycle OUT1=0xA5A5A5A5, OUT1_VALID=1, CNT1 incremented.

Source files
------------

// File: rtl/route32_pkg.sv
// Shared datapath sizing and lane-select helpers for the route32 steering block.
package route32_pkg;

    localparam int ROUTE_WIDTH = 32;
    localparam int ROUTE_CNT_W = 8;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } lane_e;

    // A lane can take a new word if it is empty or is being drained this cycle.
    function automatic logic lane_space(input logic valid, input logic take);
        return !valid || take;
    endfunction

endpackage

// File: rtl/route32_if.sv
// Input and dual-lane output handshake bundle for route32.
interface route32_if #(
    parameter int WIDTH = route32_pkg::ROUTE_WIDTH,
    parameter int CNT_W = route32_pkg::ROUTE_CNT_W
);
    logic [WIDTH-1:0] in;
    logic             in_valid;
    logic             cond;
    logic             in_ready;
    logic [WIDTH-1:0] out0;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output in, in_valid, cond, out0_ready, out1_ready,
        input  in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in, in_valid, cond, out0_ready, out1_ready,
        output in_ready, out0, out0_valid, out1, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/route32_lane_reg32.sv
// One output lane: holding register, valid flag and accepted-word counter.
module lane_reg32
    import route32_pkg::*;
#(
    parameter int WIDTH = ROUTE_WIDTH,
    parameter int CNT_W = ROUTE_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             take,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] cnt_reg;

    // A load wins over a drain so a simultaneous drain+fill keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (load) begin
            data_reg  <= data_in;
            valid_reg <= 1'b1;
            cnt_reg   <= cnt_reg + 1'b1;
        end else if (valid_reg && take) begin
            valid_reg <= 1'b0;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
    assign cnt   = cnt_reg;

endmodule

// File: rtl/route32.sv
// Steers each accepted input word into one of two independently drained lanes.
module route32
    import route32_pkg::*;
#(
    parameter int WIDTH = ROUTE_WIDTH,
    parameter int CNT_W = ROUTE_CNT_W
) (
    input  logic      clk,
    input  logic      rst,
    route32_if.slave  bus
);

    logic [WIDTH-1:0] lane_data [2];
    logic [CNT_W-1:0] lane_cnt  [2];
    logic [1:0]       lane_valid;
    logic [1:0]       lane_ready;
    logic [1:0]       lane_load;
    lane_e            sel;

    assign sel        = lane_e'(bus.cond);
    assign lane_ready = {bus.out1_ready, bus.out0_ready};

    // Ready follows only the selected lane so a stalled lane never blocks the other.
    always_comb begin
        bus.in_ready = 1'b0;
        if (!rst) begin
            if (sel == LANE1) begin
                bus.in_ready = lane_space(lane_valid[1], lane_ready[1]);
            end else begin
                bus.in_ready = lane_space(lane_valid[0], lane_ready[0]);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_load[gi] = bus.in_valid && bus.in_ready && (int'(bus.cond) == gi);

            lane_reg32 #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .load    (lane_load[gi]),
                .data_in (bus.in),
                .take    (lane_ready[gi]),
                .data    (lane_data[gi]),
                .valid   (lane_valid[gi]),
                .cnt     (lane_cnt[gi])
            );
        end
    endgenerate

    assign bus.out0       = lane_data[0];
    assign bus.out1       = lane_data[1];
    assign bus.out0_valid = lane_valid[0];
    assign bus.out1_valid = lane_valid[1];
    assign bus.cnt0       = lane_cnt[0];
    assign bus.cnt1       = lane_cnt[1];

endmodule

// File: tb/tb_route32.sv
// Directed bench for route32: reset, steering, back-pressure, throughput and counter wrap.
module tb_route32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    route32_if #(.WIDTH(32), .CNT_W(8)) bus ();

    route32 #(.WIDTH(32), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled just before the next fall.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic c, input logic [31:0] d);
        bus.in_valid = v;
        bus.cond     = c;
        bus.in       = d;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        bus.in         = '0;
        bus.in_valid   = 1'b0;
        bus.cond       = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;

        @(negedge clk);
        drive(1'b1, 1'b1, 32'h12345678);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        cycle();
        check("rst_out0", bus.out0, 0);
        check("rst_out1", bus.out1, 0);
        check("rst_valids", {bus.out1_valid, bus.out0_valid}, 0);
        check("rst_cnts", {bus.cnt1, bus.cnt0}, 0);

        // first cycle out of reset accepts immediately
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'hDEADBEEF);
        #1;
        check("first_in_ready", bus.in_ready, 1);
        cycle();
        drive(1'b0, 1'b0, 32'h0);
        check("beef_out1", bus.out1, 32'hDEADBEEF);
        check("beef_valids", {bus.out1_valid, bus.out0_valid}, 2'b10);
        check("beef_cnts", {bus.cnt1, bus.cnt0}, {8'd1, 8'd0});

        // hold under back-pressure
        cycle();
        check("hold_out1", bus.out1, 32'hDEADBEEF);
        check("hold_v1", bus.out1_valid, 1);

        // drain lane 1 with no fill: valid drops, data kept
        bus.out1_ready = 1'b1;
        cycle();
        bus.out1_ready = 1'b0;
        check("drain_v1", bus.out1_valid, 0);
        check("drain_out1", bus.out1, 32'hDEADBEEF);

        // idle input churn has no effect
        drive(1'b0, 1'b1, 32'hCAFEF00D);
        cycle();
        drive(1'b0, 1'b0, 32'h0BADF00D);
        cycle();
        check("idle_valids", {bus.out1_valid, bus.out0_valid}, 0);
        check("idle_cnts", {bus.cnt1, bus.cnt0}, {8'd1, 8'd0});

        // fill lane 0, then stall it
        drive(1'b1, 1'b0, 32'h22222222);
        cycle();
        check("fill0_out0", bus.out0, 32'h22222222);
        drive(1'b1, 1'b0, 32'h11111111);
        #1;
        check("stall0_in_ready", bus.in_ready, 0);
        cycle();
        check("stall0_out0", bus.out0, 32'h22222222);
        check("stall0_cnt0", bus.cnt0, 1);
        drive(1'b1, 1'b1, 32'h11111111);
        #1;
        check("other_lane_ready", bus.in_ready, 1);
        cycle();
        check("other_lane_out1", bus.out1, 32'h11111111);
        check("other_lane_cnt1", bus.cnt1, 2);
        check("other_lane_out0", bus.out0, 32'h22222222);

        // simultaneous drain and fill on lane 1
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b1, 32'hA5A5A5A5);
        #1;
        check("df_in_ready", bus.in_ready, 1);
        cycle();
        bus.out1_ready = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("df_out1", bus.out1, 32'hA5A5A5A5);
        check("df_v1", bus.out1_valid, 1);
        check("df_cnt1", bus.cnt1, 3);

        // both lanes full: reset with a word presented
        check("prerst_valids", {bus.out1_valid, bus.out0_valid}, 2'b11);
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h77777777);
        #1;
        check("midrst_in_ready", bus.in_ready, 0);
        cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        check("midrst_valids", {bus.out1_valid, bus.out0_valid}, 0);
        check("midrst_cnts", {bus.cnt1, bus.cnt0}, 0);
        check("midrst_out0", bus.out0, 0);

        // back-to-back into lane 0 at full throughput
        bus.out0_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 32'(i));
            #1;
            check($sformatf("b2b_ready_%0d", i), bus.in_ready, 1);
            cycle();
            check($sformatf("b2b_out0_%0d", i), bus.out0, 64'(i));
            check($sformatf("b2b_v0_%0d", i), bus.out0_valid, 1);
        end
        drive(1'b0, 1'b0, 32'h0);
        check("b2b_cnt0", bus.cnt0, 4);
        cycle();
        bus.out0_ready = 1'b0;
        check("b2b_drained", bus.out0_valid, 0);

        // 256 words into lane 1 wraps its counter
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b1, 32'(i));
            cycle();
            if (i == 254) check("wrap_cnt1_255", bus.cnt1, 255);
        end
        drive(1'b0, 1'b0, 32'h0);
        check("wrap_cnt1", bus.cnt1, 0);
        check("wrap_cnt0", bus.cnt0, 4);
        check("wrap_out1", bus.out1, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
